// File: rtl/dmem_pkg.sv
// Shared types and constants for the data-memory access unit.
// Covers FSM states, RISC-V load/store width codes and the captured request record.
package dmem_pkg;

    localparam int DMEM_ADDR_W = 9;
    localparam int DMEM_DATA_W = 32;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        RESP = 2'd2
    } dmem_state_t;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef struct packed {
        logic                   we;
        logic [DMEM_ADDR_W-1:0] addr;
        logic [2:0]             func3;
        logic [3:0]             be;
        logic [DMEM_DATA_W-1:0] wdata;
    } dmem_req_t;

    // True when func3 is a known width code and the address is aligned for it.
    function automatic logic f3_access_ok(input logic [2:0] func3, input logic [1:0] addr_lo);
        logic ok;
        case (func3)
            F3_B, F3_BU: ok = 1'b1;
            F3_H, F3_HU: ok = ~addr_lo[0];
            F3_W:        ok = (addr_lo == 2'b00);
            default:     ok = 1'b0;
        endcase
        return ok;
    endfunction

endpackage

// File: rtl/dmem_lane.sv
// Byte-lane logic: store byte enables and write-data replication, plus load
// lane extraction with sign/zero extension.
module dmem_lane
    import dmem_pkg::*;
(
    input  logic        i_we,
    input  logic [2:0]  i_func3,
    input  logic [1:0]  i_addr_lo,
    input  logic [31:0] i_wdata,
    input  logic [31:0] i_rdata,
    output logic [3:0]  o_be,
    output logic [31:0] o_wdata,
    output logic [31:0] o_rdata_ext
);

    logic [7:0]  w_byte;
    logic [15:0] w_half;

    always_comb begin
        o_be    = 4'b1111;
        o_wdata = '0;
        if (i_we) begin
            case (i_func3[1:0])
                2'b00: begin
                    o_be    = 4'b0001 << i_addr_lo;
                    o_wdata = {4{i_wdata[7:0]}};
                end
                2'b01: begin
                    o_be    = i_addr_lo[1] ? 4'b1100 : 4'b0011;
                    o_wdata = {2{i_wdata[15:0]}};
                end
                default: begin
                    o_be    = 4'b1111;
                    o_wdata = i_wdata;
                end
            endcase
        end
    end

    always_comb begin
        w_byte = i_rdata[7:0];
        case (i_addr_lo)
            2'd0:    w_byte = i_rdata[7:0];
            2'd1:    w_byte = i_rdata[15:8];
            2'd2:    w_byte = i_rdata[23:16];
            default: w_byte = i_rdata[31:24];
        endcase
        w_half = i_addr_lo[1] ? i_rdata[31:16] : i_rdata[15:0];

        o_rdata_ext = i_rdata;
        case (i_func3)
            F3_B:    o_rdata_ext = {{24{w_byte[7]}}, w_byte};
            F3_BU:   o_rdata_ext = {24'b0, w_byte};
            F3_H:    o_rdata_ext = {{16{w_half[15]}}, w_half};
            F3_HU:   o_rdata_ext = {16'b0, w_half};
            default: o_rdata_ext = i_rdata;
        endcase
    end

endmodule

// File: rtl/dmem_access_unit.sv
// Load/store controller between EX/MEM and a variable-latency handshaked data
// memory; stalls the pipeline until completion, timeout abort, or fault rejection.
module dmem_access_unit
    import dmem_pkg::*;
#(
    parameter int DM_ADDRESS = 9,
    parameter int DATA_W     = 32,
    parameter int TIMEOUT    = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  mem_read,
    input  logic                  mem_write,
    input  logic [DM_ADDRESS-1:0] addr,
    input  logic [DATA_W-1:0]     wr_data,
    input  logic [2:0]            func3,
    output logic                  stall,
    output logic [DATA_W-1:0]     rd_data,
    output logic                  rd_valid,
    output logic                  access_fault,
    output logic                  bus_err,
    output logic                  m_req,
    output logic                  m_we,
    output logic [DM_ADDRESS-3:0] m_addr,
    output logic [3:0]            m_be,
    output logic [DATA_W-1:0]     m_wdata,
    input  logic                  m_ready,
    input  logic [DATA_W-1:0]     m_rdata
);

    // TIMEOUT must be at least 2 so the counter has a nonzero width.
    localparam int              CNT_W    = $clog2(TIMEOUT);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    dmem_state_t      r_state;
    dmem_state_t      w_next;
    dmem_req_t        r_req;
    logic [CNT_W-1:0] r_cnt;
    logic             r_abort;
    logic [DATA_W-1:0] r_rd_data;

    logic        w_illegal;
    logic        w_accept;
    logic        w_timeout;
    logic [3:0]  w_in_be;
    logic [31:0] w_in_wdata;
    logic [31:0] w_ld_ext;
    logic [31:0] w_unused_in_ext;
    logic [3:0]  w_unused_cap_be;
    logic [31:0] w_unused_cap_wdata;

    assign w_illegal = (mem_read & mem_write) | ~f3_access_ok(func3, addr[1:0]);

    dmem_lane u_lane_in (
        .i_we        (mem_write),
        .i_func3     (func3),
        .i_addr_lo   (addr[1:0]),
        .i_wdata     (wr_data),
        .i_rdata     (32'h0),
        .o_be        (w_in_be),
        .o_wdata     (w_in_wdata),
        .o_rdata_ext (w_unused_in_ext)
    );

    dmem_lane u_lane_cap (
        .i_we        (r_req.we),
        .i_func3     (r_req.func3),
        .i_addr_lo   (r_req.addr[1:0]),
        .i_wdata     (32'h0),
        .i_rdata     (m_rdata),
        .o_be        (w_unused_cap_be),
        .o_wdata     (w_unused_cap_wdata),
        .o_rdata_ext (w_ld_ext)
    );

    always_comb begin
        w_next       = r_state;
        stall        = 1'b0;
        access_fault = 1'b0;
        bus_err      = 1'b0;
        rd_valid     = 1'b0;
        m_req        = 1'b0;
        w_accept     = 1'b0;
        w_timeout    = 1'b0;
        case (r_state)
            IDLE: begin
                if (mem_read | mem_write) begin
                    if (w_illegal) begin
                        access_fault = 1'b1;
                    end else begin
                        stall    = 1'b1;
                        w_accept = 1'b1;
                        w_next   = REQ;
                    end
                end
            end
            REQ: begin
                m_req = 1'b1;
                stall = 1'b1;
                if (m_ready) begin
                    w_next = RESP;
                end else if (r_cnt == CNT_LAST) begin
                    w_timeout = 1'b1;
                    w_next    = RESP;
                end
            end
            RESP: begin
                // Pipeline inputs still belong to the finished instruction here.
                rd_valid = ~r_abort & ~r_req.we;
                bus_err  = r_abort;
                w_next   = IDLE;
            end
            default: w_next = IDLE;
        endcase
    end

    assign m_we    = m_req & r_req.we;
    assign m_addr  = m_req ? r_req.addr[DM_ADDRESS-1:2] : '0;
    assign m_be    = m_req ? r_req.be : 4'b0000;
    assign m_wdata = m_req ? r_req.wdata : '0;
    assign rd_data = r_rd_data;

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state   <= IDLE;
            r_req     <= '0;
            r_cnt     <= '0;
            r_abort   <= 1'b0;
            r_rd_data <= '0;
        end else begin
            r_state <= w_next;
            if (w_accept) begin
                r_req.we    <= mem_write;
                r_req.addr  <= addr;
                r_req.func3 <= func3;
                r_req.be    <= w_in_be;
                r_req.wdata <= w_in_wdata;
                r_cnt       <= '0;
                r_abort     <= 1'b0;
            end
            if (r_state == REQ) begin
                if (m_ready) begin
                    if (!r_req.we) r_rd_data <= w_ld_ext;
                end else if (w_timeout) begin
                    r_abort   <= 1'b1;
                    r_rd_data <= '0;
                end else begin
                    r_cnt <= r_cnt + CNT_W'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_dmem_access_unit.sv
// Self-checking bench for dmem_access_unit: directed cases, timeout, reset
// mid-access and randomized aligned loads/stores against a small lane model.
module tb_dmem_access_unit;
    import dmem_pkg::*;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        mem_read = 1'b0;
    logic        mem_write = 1'b0;
    logic [8:0]  addr = '0;
    logic [31:0] wr_data = '0;
    logic [2:0]  func3 = '0;
    logic        stall;
    logic [31:0] rd_data;
    logic        rd_valid;
    logic        access_fault;
    logic        bus_err;
    logic        m_req;
    logic        m_we;
    logic [6:0]  m_addr;
    logic [3:0]  m_be;
    logic [31:0] m_wdata;
    logic        m_ready = 1'b0;
    logic [31:0] m_rdata = '0;

    dmem_access_unit #(.DM_ADDRESS(9), .DATA_W(32), .TIMEOUT(16)) dut (
        .clk          (clk),
        .reset        (reset),
        .mem_read     (mem_read),
        .mem_write    (mem_write),
        .addr         (addr),
        .wr_data      (wr_data),
        .func3        (func3),
        .stall        (stall),
        .rd_data      (rd_data),
        .rd_valid     (rd_valid),
        .access_fault (access_fault),
        .bus_err      (bus_err),
        .m_req        (m_req),
        .m_we         (m_we),
        .m_addr       (m_addr),
        .m_be         (m_be),
        .m_wdata      (m_wdata),
        .m_ready      (m_ready),
        .m_rdata      (m_rdata)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    // Entries are {rd_valid, bus_err, rd_data} expected in the RESP cycle.
    logic [33:0] exp_q[$];

    logic        cap_we;
    logic [6:0]  cap_addr;
    logic [3:0]  cap_be;
    logic [31:0] cap_wdata;
    logic        cap_fault;
    int          cap_stall;
    int          cap_req;
    int          cap_unstable;

    logic [8:0]  f_addr [4] = '{9'h006, 9'h005, 9'h000, 9'h000};
    logic [2:0]  f_f3   [4] = '{3'b010, 3'b001, 3'b011, 3'b010};
    logic        f_wr   [4] = '{1'b0, 1'b0, 1'b0, 1'b1};
    logic [2:0]  f3_tbl [5] = '{3'b000, 3'b001, 3'b010, 3'b100, 3'b101};

    logic        r_st;
    logic [2:0]  r_f3;
    logic [1:0]  r_lo;
    logic [6:0]  r_hi;
    logic [31:0] r_d;
    logic [31:0] r_w;
    int          r_dly;
    int          r_kind;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] want);
        n_checks++;
        if (got !== want) $display("FAIL %s: got %h expected %h", tag, got, want);
        else n_pass++;
    endtask

    function automatic logic [31:0] model_load(input logic [2:0] f3, input logic [1:0] lo,
                                               input logic [31:0] w);
        logic [31:0] sh;
        sh = w >> {lo, 3'b000};
        case (f3)
            3'b000:  return {{24{sh[7]}}, sh[7:0]};
            3'b100:  return {24'b0, sh[7:0]};
            3'b001:  return {{16{sh[15]}}, sh[15:0]};
            3'b101:  return {16'b0, sh[15:0]};
            default: return w;
        endcase
    endfunction

    function automatic logic [3:0] model_be(input logic st, input logic [2:0] f3, input logic [1:0] lo);
        if (!st) return 4'hF;
        case (f3[1:0])
            2'b00:   return 4'b0001 << lo;
            2'b01:   return 4'b0011 << lo;
            default: return 4'hF;
        endcase
    endfunction

    function automatic logic [31:0] model_wdata(input logic st, input logic [2:0] f3, input logic [31:0] d);
        if (!st) return 32'h0;
        case (f3[1:0])
            2'b00:   return {4{d[7:0]}};
            2'b01:   return {2{d[15:0]}};
            default: return d;
        endcase
    endfunction

    // Called at posedge+1; returns at posedge+1 after the non-stalled cycle.
    task automatic do_access(input logic rd, input logic wr, input logic [8:0] a,
                             input logic [31:0] wd, input logic [2:0] f3,
                             input int delay, input logic [31:0] rdata);
        bit done;
        done = 1'b0;
        cap_stall = 0; cap_req = 0; cap_unstable = 0; cap_fault = 1'b0;
        cap_we = 1'b0; cap_addr = '0; cap_be = '0; cap_wdata = '0;
        mem_read = rd; mem_write = wr; addr = a; wr_data = wd; func3 = f3;
        m_rdata = rdata; m_ready = 1'b0;
        for (int c = 0; c < 64 && !done; c++) begin
            @(negedge clk);
            if (stall) cap_stall++;
            if (access_fault) cap_fault = 1'b1;
            if (m_req) begin
                if (cap_req == 0) begin
                    cap_we = m_we; cap_addr = m_addr; cap_be = m_be; cap_wdata = m_wdata;
                end else if ({m_we, m_addr, m_be, m_wdata} !== {cap_we, cap_addr, cap_be, cap_wdata}) begin
                    cap_unstable++;
                end
                cap_req++;
                m_ready = (cap_req > delay);
            end else begin
                m_ready = 1'b0;
            end
            if (!stall) done = 1'b1;
            @(posedge clk);
            #1;
        end
        mem_read = 1'b0; mem_write = 1'b0; m_ready = 1'b0;
        chk("acc_done", 64'(done), 64'(1));
    endtask

    always @(negedge clk) begin
        if (rd_valid || bus_err) begin
            if (exp_q.size() == 0) chk("spurious_resp", 64'({rd_valid, bus_err, rd_data}), 64'(0));
            else chk("resp", 64'({rd_valid, bus_err, rd_data}), 64'(exp_q.pop_front()));
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_ctrl", 64'({stall, rd_valid, access_fault, bus_err, m_req, m_we}), 64'(0));
        chk("rst_bus", 64'({m_addr, m_be, m_wdata}), 64'(0));
        chk("rst_rdata", 64'(rd_data), 64'(0));
        @(posedge clk); #1;
        reset = 1'b1;
        @(posedge clk); #1;

        // Word store, immediate ready
        do_access(1'b0, 1'b1, 9'h010, 32'hDEADBEEF, F3_W, 0, 32'h0);
        chk("sw_stall", 64'(cap_stall), 64'(2));
        chk("sw_req", 64'(cap_req), 64'(1));
        chk("sw_bus", 64'({cap_we, cap_addr, cap_be}), 64'({1'b1, 7'h04, 4'hF}));
        chk("sw_wdata", 64'(cap_wdata), 64'(32'hDEADBEEF));

        // Byte loads with delayed ready
        exp_q.push_back({2'b10, 32'hFFFFFF80});
        do_access(1'b1, 1'b0, 9'h013, 32'h0, F3_B, 3, 32'h80FF7F01);
        chk("lb_stall", 64'(cap_stall), 64'(5));
        chk("lb_req", 64'(cap_req), 64'(4));
        chk("lb_bus", 64'({cap_we, cap_addr, cap_be, cap_wdata}), 64'({1'b0, 7'h04, 4'hF, 32'h0}));
        chk("lb_stable", 64'(cap_unstable), 64'(0));
        chk("lb_drain", 64'(exp_q.size()), 64'(0));
        exp_q.push_back({2'b10, 32'h00000080});
        do_access(1'b1, 1'b0, 9'h013, 32'h0, F3_BU, 3, 32'h80FF7F01);
        chk("lbu_stall", 64'(cap_stall), 64'(5));
        chk("lbu_drain", 64'(exp_q.size()), 64'(0));

        // Halfword store and loads in the upper lane
        do_access(1'b0, 1'b1, 9'h00E, 32'h0000ABCD, F3_H, 1, 32'h0);
        chk("sh_bus", 64'({cap_we, cap_addr, cap_be}), 64'({1'b1, 7'h03, 4'hC}));
        chk("sh_wdata", 64'(cap_wdata), 64'(32'hABCDABCD));
        exp_q.push_back({2'b10, 32'h00009A5C});
        do_access(1'b1, 1'b0, 9'h00E, 32'h0, F3_HU, 0, 32'h9A5C0000);
        exp_q.push_back({2'b10, 32'hFFFF9A5C});
        do_access(1'b1, 1'b0, 9'h00E, 32'h0, F3_H, 2, 32'h9A5C0000);
        chk("lh_drain", 64'(exp_q.size()), 64'(0));

        // Rejected requests
        for (int i = 0; i < 4; i++) begin
            do_access(1'b1, f_wr[i], f_addr[i], 32'h0, f_f3[i], 0, 32'h0);
            chk($sformatf("fault%0d_pulse", i), 64'(cap_fault), 64'(1));
            chk($sformatf("fault%0d_req", i), 64'(cap_req), 64'(0));
            chk($sformatf("fault%0d_stall", i), 64'(cap_stall), 64'(0));
        end

        // Timeout abort, then a stray ready outside REQ
        exp_q.push_back({2'b01, 32'h0});
        do_access(1'b1, 1'b0, 9'h020, 32'h0, F3_W, 1000, 32'h12345678);
        chk("to_req", 64'(cap_req), 64'(16));
        chk("to_stall", 64'(cap_stall), 64'(17));
        chk("to_drain", 64'(exp_q.size()), 64'(0));
        m_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("stray_ready", 64'({m_req, stall}), 64'(0));
            @(posedge clk); #1;
        end
        m_ready = 1'b0;

        // Randomized aligned accesses
        for (int i = 0; i < 24; i++) begin
            r_kind = int'($urandom_range(0, 4));
            r_st   = 1'($urandom_range(0, 1));
            r_f3   = f3_tbl[r_kind];
            if (r_st && r_kind >= 3) r_f3 = f3_tbl[r_kind - 3];
            if (r_f3[1:0] == 2'b00)      r_lo = 2'($urandom_range(0, 3));
            else if (r_f3[1:0] == 2'b01) r_lo = {1'($urandom_range(0, 1)), 1'b0};
            else                         r_lo = 2'b00;
            r_hi  = 7'($urandom_range(0, 127));
            r_d   = $urandom;
            r_w   = $urandom;
            r_dly = int'($urandom_range(0, 4));
            if (!r_st) exp_q.push_back({2'b10, model_load(r_f3, r_lo, r_w)});
            do_access(!r_st, r_st, {r_hi, r_lo}, r_d, r_f3, r_dly, r_w);
            chk("rnd_stall", 64'(cap_stall), 64'(r_dly + 2));
            chk("rnd_bus", 64'({cap_we, cap_addr, cap_be}), 64'({r_st, r_hi, model_be(r_st, r_f3, r_lo)}));
            chk("rnd_wdata", 64'(cap_wdata), 64'(model_wdata(r_st, r_f3, r_d)));
        end

        // Back-to-back LW then SW, reset during the SW's second REQ cycle
        exp_q.push_back({2'b10, 32'hCAFEF00D});
        do_access(1'b1, 1'b0, 9'h040, 32'h0, F3_W, 0, 32'hCAFEF00D);
        chk("b2b_lw_stall", 64'(cap_stall), 64'(2));
        mem_write = 1'b1; addr = 9'h044; func3 = F3_W; wr_data = 32'h11223344; m_ready = 1'b0;
        @(negedge clk);
        chk("b2b_sw_idle", 64'(stall), 64'(1));
        @(posedge clk); #1;
        @(negedge clk);
        chk("b2b_sw_req1", 64'(m_req), 64'(1));
        @(posedge clk); #1;
        reset = 1'b0;
        mem_write = 1'b0;
        @(negedge clk);
        chk("b2b_sw_req2", 64'(m_req), 64'(1));
        @(posedge clk); #1;
        @(negedge clk);
        chk("rst_mid", 64'({m_req, stall, rd_valid, bus_err, access_fault}), 64'(0));
        @(posedge clk); #1;
        reset = 1'b1;
        @(posedge clk); #1;
        exp_q.push_back({2'b10, 32'h0BADC0DE});
        do_access(1'b1, 1'b0, 9'h048, 32'h0, F3_W, 0, 32'h0BADC0DE);
        chk("post_rst_req", 64'(cap_req), 64'(1));
        chk("post_rst_stall", 64'(cap_stall), 64'(2));

        repeat (2) @(posedge clk);
        chk("q_empty", 64'(exp_q.size()), 64'(0));
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/dmem_access_unit.md
Name: dmem_access_unit

Overview:
- Data-memory access controller between the EX/MEM pipeline register and a handshaked data memory with variable latency.
- Accepts one load or store per instruction and converts func3 and address into word address, byte enables and lane-replicated write data.
- Sign- or zero-extends load data.
- Stalls the pipeline until the access completes, is aborted on timeout, or is rejected as a fault.

Parameters:
DM_ADDRESS, 9, byte address width from the pipeline
DATA_W, 32, data width (fixed at 32; byte lanes assume 4 bytes)
TIMEOUT, 16, maximum REQ-state cycles without mem_ready before abort

Ports:
clk  input  1  clock, rising edge
reset  input  1  synchronous reset, active-low (reset=0 clears state at the next rising edge of clk)
mem_read  input  1  load request from EX/MEM
mem_write  input  1  store request from EX/MEM
addr  input  DM_ADDRESS  byte address
wr_data  input  DATA_W  store data (forwarded rs2)
func3  input  3  RISC-V width/sign code
stall  output  1  hold PC, IF/ID, ID/EX and EX/MEM
rd_data  output  DATA_W  extended load result
rd_valid  output  1  rd_data valid this cycle
access_fault  output  1  one-cycle pulse: misaligned, illegal func3, or read+write both set
bus_err  output  1  one-cycle pulse: timeout abort
m_req  output  1  memory request
m_we  output  1  memory write
m_addr  output  DM_ADDRESS-2  word address
m_be  output  4  byte enables
m_wdata  output  DATA_W  lane-replicated write data
m_ready  input  1  memory accept/complete
m_rdata  input  DATA_W  memory read word

Behaviour:
- Reset values: state IDLE, timeout counter 0, all latched request fields 0. All outputs are 0.
- Reset mid-access drops m_req at that edge; there is no completion pulse.
- FSM states:
  - IDLE: no access outstanding.
  - REQ: access outstanding on the memory bus.
  - RESP: one-cycle release.
- IDLE with neither mem_read nor mem_write: stall=0 and no outputs asserted.
- IDLE with a request that is illegal:
  - Illegal means any of: both mem_read and mem_write; func3 in {011,110,111}; halfword with addr[0]=1; word with addr[1:0]!=0.
  - access_fault=1 combinationally that cycle and stall=0.
  - No memory access; state stays IDLE.
- IDLE with a legal request:
  - stall=1 combinationally.
  - At the edge, latch addr, func3, write flag, m_be and m_wdata; clear the counter; go to REQ.
- REQ:
  - m_req=1, stall=1, and m_we, m_addr, m_be, m_wdata are driven from the latched registers, stable until m_ready.
  - On m_ready=1: for a load, latch the extended load data; go to RESP.
  - Otherwise the counter increments. When the counter reaches TIMEOUT-1 without m_ready, go to RESP with an abort flag and the load data forced to 0.
- RESP:
  - stall=0.
  - For a completed load, rd_valid=1 and rd_data is the latched value.
  - For an aborted access, bus_err=1 and rd_data=0.
  - The pipeline advances at this edge. Inputs are ignored this cycle, because they still belong to the finished instruction. Go to IDLE.
- Latency: minimum 2 stall cycles (IDLE detect, then REQ with m_ready=1), plus RESP, for 3 cycles in total.
- rd_data holds its last value outside RESP; it is meaningful only when rd_valid=1.
- Store lanes:
  - SB: m_be = 0001 shifted left by addr[1:0]; m_wdata = byte replicated 4 times.
  - SH: m_be = 0011 when addr[1]=0, 1100 when addr[1]=1; m_wdata = halfword replicated 2 times.
  - SW: m_be = 1111.
  - For a load, m_be=1111 and m_wdata=0.
- Load extraction:
  - Byte lane is selected by the latched addr[1:0]; halfword lane by addr[1].
  - LB and LH sign-extend; LBU and LHU zero-extend; LW passes the word through.
- Bus rule: m_ready is sampled only in REQ. m_ready outside REQ is ignored.

Decomposition:
- Package dmem_pkg holds:
  - state enum dmem_state_t {IDLE, REQ, RESP};
  - func3 constants F3_B=000, F3_H=001, F3_W=010, F3_BU=100, F3_HU=101;
  - request struct dmem_req_t {we, addr, func3, be, wdata}.
- Sub-module dmem_lane (purely combinational) provides both the store-lane encoder and the load extractor. It is instantiated twice: once on the input side and once on the captured-data side.

Test Plan:
1. SW addr=0x010, wr_data=0xDEADBEEF, m_ready high in the first REQ cycle -> m_addr=0x04, m_be=1111, m_wdata=0xDEADBEEF; stall high for exactly 2 cycles; no rd_valid.
2. LB addr=0x013, m_rdata=0x80FF7F01, m_ready delayed 3 cycles -> stall high for 5 cycles; rd_data=0xFFFFFF80 with rd_valid for 1 cycle. Repeat with LBU -> rd_data=0x00000080.
3. SH addr=0x00E, wr_data=0x0000ABCD -> m_be=1100, m_wdata=0xABCDABCD. Then LHU addr=0x00E with m_rdata=0x9A5C0000 -> rd_data=0x00009A5C; LH -> rd_data=0xFFFF9A5C.
4. Faults, each case -> access_fault pulse, m_req never asserted, stall=0:
   - LW addr=0x006;
   - LH addr=0x005;
   - func3=011;
   - mem_read=mem_write=1.
5. LW with m_ready held low and TIMEOUT=16 -> m_req high for 16 cycles; then bus_err=1 and rd_data=0 in RESP; IDLE the next cycle; a later m_ready pulse has no effect.
6. Back-to-back LW then SW, with reset=0 asserted in the 2nd REQ cycle of the SW -> the LW completes normally; at the reset edge m_req=0, stall=0 and no pulses; after reset=1 the unit accepts a new LW.
